// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory wait, mult/div,
// taken-branch and load-use hazards into register enables, flushes and a stall counter.
module pipeline_ctrl #(
    parameter int MD_LAT      = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_use_hazard,
    input  logic        branch_taken_ex,
    input  logic        md_req_ex,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        memwb_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        md_start,
    output logic        md_done,
    output logic        mem_err,
    output logic [15:0] stall_cycles
);

    localparam int MDW = ($clog2(MD_LAT) < 2) ? 2 : $clog2(MD_LAT);
    localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_LAT - 1);
    localparam logic [MDW-1:0] MD_ONE  = MDW'(1);
    localparam logic [7:0]     TIMEOUT = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_BUSY  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [MDW-1:0]  md_cnt_r;
    logic [MDW-1:0]  md_cnt_nxt_s;
    logic [7:0]      wait_cnt_r;
    logic [7:0]      wait_cnt_nxt_s;
    logic            mem_err_r;
    logic [15:0]     stall_cnt_r;

    logic            pc_we_s;
    logic            ifid_we_s;
    logic            idex_we_s;
    logic            exmem_we_s;
    logic            memwb_we_s;
    logic            ifid_flush_s;
    logic            idex_flush_s;
    logic            exmem_flush_s;
    logic            md_start_s;
    logic            md_done_s;
    logic            rules_en_s;
    logic            md_allow_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        sat_inc8 = (val == 8'hFF) ? 8'hFF : (val + 8'd1);
    endfunction

    // Next state and hazard arbitration; the rule block below is shared by every state
    always_comb begin
        pc_we_s        = 1'b1;
        ifid_we_s      = 1'b1;
        idex_we_s      = 1'b1;
        exmem_we_s     = 1'b1;
        memwb_we_s     = 1'b1;
        ifid_flush_s   = 1'b0;
        idex_flush_s   = 1'b0;
        exmem_flush_s  = 1'b0;
        md_start_s     = 1'b0;
        md_done_s      = 1'b0;
        rules_en_s     = 1'b0;
        md_allow_s     = 1'b0;
        state_nxt_s    = state_r;
        md_cnt_nxt_s   = md_cnt_r;
        wait_cnt_nxt_s = wait_cnt_r;

        case (state_r)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    {pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s} = 5'b00000;
                    wait_cnt_nxt_s = sat_inc8(wait_cnt_r);
                    state_nxt_s    = MEM_WAIT;
                end else begin
                    rules_en_s = 1'b1;
                    md_allow_s = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    {pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s} = 5'b00000;
                    wait_cnt_nxt_s = sat_inc8(wait_cnt_r);
                end else begin
                    wait_cnt_nxt_s = 8'd0;
                    state_nxt_s    = RUN;
                    rules_en_s     = 1'b1;
                    md_allow_s     = 1'b1;
                end
            end
            MD_BUSY: begin
                md_cnt_nxt_s = md_cnt_r - MD_ONE;
                if (md_cnt_r > MD_ONE) begin
                    {pc_we_s, ifid_we_s, idex_we_s} = 3'b000;
                    exmem_flush_s = 1'b1;
                end else begin
                    // md_req_ex still names the finishing op, so no restart here
                    md_done_s   = 1'b1;
                    rules_en_s  = 1'b1;
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase

        if (rules_en_s) begin
            if (md_allow_s && md_req_ex) begin
                md_start_s    = 1'b1;
                {pc_we_s, ifid_we_s, idex_we_s} = 3'b000;
                exmem_flush_s = 1'b1;
                md_cnt_nxt_s  = MD_LOAD;
                state_nxt_s   = MD_BUSY;
            end else if (branch_taken_ex) begin
                ifid_flush_s = 1'b1;
                idex_flush_s = 1'b1;
            end else if (load_use_hazard) begin
                pc_we_s      = 1'b0;
                ifid_we_s    = 1'b0;
                idex_flush_s = 1'b1;
            end else begin
                md_start_s = 1'b0;
            end
        end else begin
            md_start_s = 1'b0;
        end
    end

    // Controller state, counters and sticky watchdog flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RUN;
            md_cnt_r    <= '0;
            wait_cnt_r  <= 8'd0;
            mem_err_r   <= 1'b0;
            stall_cnt_r <= 16'd0;
        end else begin
            state_r    <= state_nxt_s;
            md_cnt_r   <= md_cnt_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if ((wait_cnt_nxt_s == TIMEOUT) && (wait_cnt_nxt_s != 8'd0)) begin
                mem_err_r <= 1'b1;
            end else begin
                mem_err_r <= mem_err_r;
            end
            if (!pc_we_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // Control outputs are Mealy; reset forces every enable and pulse low
    always_comb begin
        pc_we        = rst_n & pc_we_s;
        ifid_we      = rst_n & ifid_we_s;
        idex_we      = rst_n & idex_we_s;
        exmem_we     = rst_n & exmem_we_s;
        memwb_we     = rst_n & memwb_we_s;
        ifid_flush   = rst_n & ifid_flush_s;
        idex_flush   = rst_n & idex_flush_s;
        exmem_flush  = rst_n & exmem_flush_s;
        md_start     = rst_n & md_start_s;
        md_done      = rst_n & md_done_s;
        mem_err      = mem_err_r;
        stall_cycles = stall_cnt_r;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-timeline reference model.
module tb_pipeline_ctrl;

    localparam int MD_LAT      = 4;
    localparam int MEM_TIMEOUT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_use_hazard = 1'b0;
    logic        branch_taken_ex = 1'b0;
    logic        md_req_ex = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic        ifid_flush, idex_flush, exmem_flush, md_start, md_done, mem_err;
    logic [15:0] stall_cycles;
    logic [9:0]  outs;

    int checks = 0;
    int errors = 0;

    // reference model: op age since md_start, memory wait status, stall tallies
    int          m_md_age;
    bit          m_waiting;
    int          m_run;
    bit          m_err;
    int          m_stalls;
    logic [9:0]  e_outs;
    bit          e_memstall;

    pipeline_ctrl #(.MD_LAT(MD_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_hazard(load_use_hazard), .branch_taken_ex(branch_taken_ex),
        .md_req_ex(md_req_ex), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .exmem_we(exmem_we), .memwb_we(memwb_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .md_start(md_start), .md_done(md_done), .mem_err(mem_err),
        .stall_cycles(stall_cycles)
    );

    assign outs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                   ifid_flush, idex_flush, exmem_flush, md_start, md_done};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit lu, input bit br, input bit md, input bit mq, input bit mr);
        load_use_hazard = lu;
        branch_taken_ex = br;
        md_req_ex       = md;
        mem_req         = mq;
        mem_ready       = mr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 1);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 1, 1, 0);
        #3;
        if (outs !== 10'b0) begin
            errors++;
            $display("FAIL reset_outs got=%b want=%b", outs, 10'b0);
        end
        checks++;
        if (stall_cycles !== 16'd0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got stall=%0d err=%b want 0/0", stall_cycles, mem_err);
        end
        checks++;
        tick();
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 1);
        #1;
        if (outs !== 10'b0011101000) begin
            errors++;
            $display("FAIL load_use_bubble got=%b want=%b", outs, 10'b0011101000);
        end
        checks++;
        tick();
        drive(0, 0, 0, 0, 1);
        #1;
        if (outs !== 10'b1111100000) begin
            errors++;
            $display("FAIL load_use_resume got=%b want=%b", outs, 10'b1111100000);
        end
        checks++;
        if (stall_cycles !== 16'd1) begin
            errors++;
            $display("FAIL load_use_stalls got=%0d want=1", stall_cycles);
        end
        checks++;
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        drive(1, 1, 0, 0, 1);
        #1;
        if (outs !== 10'b1111111000) begin
            errors++;
            $display("FAIL branch_flush got=%b want=%b", outs, 10'b1111111000);
        end
        checks++;
        tick();
        drive(0, 0, 0, 0, 1);
        #1;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL branch_stalls got=%0d want=0", stall_cycles);
        end
        checks++;
        tick();
    endtask

    task automatic test_muldiv();
        logic [9:0] want;
        do_reset();
        drive(0, 1, 1, 0, 1);
        for (int t = 0; t < MD_LAT + 1; t++) begin
            if (t == MD_LAT) drive(0, 0, 0, 0, 1);
            #1;
            if (t == 0)                want = 10'b0001100110;
            else if (t < MD_LAT - 1)   want = 10'b0001100100;
            else if (t == MD_LAT - 1)  want = 10'b1111111001;
            else                       want = 10'b1111100000;
            if (outs !== want) begin
                errors++;
                $display("FAIL muldiv_T%0d got=%b want=%b", t, outs, want);
            end
            checks++;
            tick();
        end
        if (stall_cycles !== 16'(MD_LAT - 1)) begin
            errors++;
            $display("FAIL muldiv_stalls got=%0d want=%0d", stall_cycles, MD_LAT - 1);
        end
        checks++;
    endtask

    task automatic test_mem_stall();
        do_reset();
        drive(0, 0, 0, 1, 0);
        for (int t = 0; t < 4; t++) begin
            if (t == 3) mem_ready = 1'b1;
            #1;
            if (outs !== ((t < 3) ? 10'b0000000000 : 10'b1111100000)) begin
                errors++;
                $display("FAIL mem_stall_c%0d got=%b want=%b", t, outs,
                         (t < 3) ? 10'b0000000000 : 10'b1111100000);
            end
            checks++;
            tick();
        end
        drive(0, 0, 0, 0, 1);
        if (dut.wait_cnt_r !== 8'd0 || stall_cycles !== 16'd3 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL mem_stall_after got wait=%0d stall=%0d err=%b want 0/3/0",
                     dut.wait_cnt_r, stall_cycles, mem_err);
        end
        checks++;
    endtask

    task automatic test_timeout();
        do_reset();
        drive(0, 0, 0, 1, 0);
        for (int k = 0; k <= MEM_TIMEOUT + 1; k++) begin
            #1;
            if (mem_err !== (k >= MEM_TIMEOUT)) begin
                errors++;
                $display("FAIL timeout_after_%0d got=%b want=%b", k, mem_err, k >= MEM_TIMEOUT);
            end
            checks++;
            tick();
        end
        mem_ready = 1'b1;
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        if (mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got=%b want=1", mem_err);
        end
        checks++;
        rst_n = 1'b0;
        #1;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cleared got=%b want=0", mem_err);
        end
        checks++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset_abort();
        do_reset();
        drive(0, 0, 1, 0, 1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        if (outs !== 10'b0 || stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL abort_reset got=%b stall=%0d want=0/0", outs, stall_cycles);
        end
        checks++;
        tick();
        rst_n = 1'b1;
        #1;
        if (outs !== 10'b0001100110) begin
            errors++;
            $display("FAIL abort_fresh_start got=%b want=%b", outs, 10'b0001100110);
        end
        checks++;
        tick();
        drive(0, 0, 0, 0, 1);
        repeat (MD_LAT - 2) tick();
        #1;
        if (outs !== 10'b1111100001) begin
            errors++;
            $display("FAIL abort_fresh_done got=%b want=%b", outs, 10'b1111100001);
        end
        checks++;
        tick();
        if (stall_cycles !== 16'(MD_LAT - 1)) begin
            errors++;
            $display("FAIL abort_stalls got=%0d want=%0d", stall_cycles, MD_LAT - 1);
        end
        checks++;
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1, 0, 0, 0, 1);
        repeat (65540) tick();
        drive(0, 0, 0, 0, 1);
        if (stall_cycles !== 16'hFFFF) begin
            errors++;
            $display("FAIL stall_saturate got=%h want=%h", stall_cycles, 16'hFFFF);
        end
        checks++;
    endtask

    task automatic predict();
        logic [4:0] we;
        logic [2:0] fl;
        bit st, dn, rules, mdok;
        we = 5'b11111; fl = 3'b000; st = 0; dn = 0; rules = 0; mdok = 0;
        e_memstall = 0;
        if (m_md_age > 0) begin
            if (m_md_age < MD_LAT - 1) begin
                we[4:2] = 3'b000;
                fl[0]   = 1'b1;
            end else begin
                dn    = 1;
                rules = 1;
            end
        end else if ((m_waiting || mem_req) && !mem_ready) begin
            we         = 5'b00000;
            e_memstall = 1;
        end else begin
            rules = 1;
            mdok  = 1;
        end
        if (rules) begin
            if (mdok && md_req_ex) begin
                st      = 1;
                we[4:2] = 3'b000;
                fl[0]   = 1'b1;
            end else if (branch_taken_ex) begin
                fl[2:1] = 2'b11;
            end else if (load_use_hazard) begin
                we[4:3] = 2'b00;
                fl[1]   = 1'b1;
            end
        end
        e_outs = {we, fl, st, dn};
    endtask

    task automatic advance();
        if (e_outs[1]) m_md_age = 1;
        else if (m_md_age > 0) m_md_age = (m_md_age >= MD_LAT - 1) ? 0 : m_md_age + 1;
        if (e_memstall) begin
            m_waiting = 1;
            m_run++;
            if (m_run >= MEM_TIMEOUT) m_err = 1;
        end else begin
            m_waiting = 0;
            m_run     = 0;
        end
        if (!e_outs[9] && m_stalls < 65535) m_stalls++;
    endtask

    task automatic test_random();
        do_reset();
        m_md_age = 0; m_waiting = 0; m_run = 0; m_err = 0; m_stalls = 0;
        for (int c = 0; c < 2000; c++) begin
            drive($urandom_range(99, 0) < 20, $urandom_range(99, 0) < 20,
                  $urandom_range(99, 0) < 15, $urandom_range(99, 0) < 40,
                  $urandom_range(99, 0) < 75);
            #1;
            predict();
            if (outs !== e_outs || mem_err !== m_err || stall_cycles !== 16'(m_stalls)) begin
                errors++;
                $display("FAIL random_c%0d got=%b/%b/%0d want=%b/%b/%0d", c,
                         outs, mem_err, stall_cycles, e_outs, m_err, m_stalls);
            end
            checks++;
            advance();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_mem_stall();
        test_timeout();
        test_reset_abort();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
